// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the EXE-stage multiply/divide unit.
// Holds the operation codes decoded in ID, the FSM state encoding and
// the default datapath width, plus small op-class helpers.
package exe_muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the four iterative ops; MTHI/MTLO/NOP/invalid are not.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/exe_muldiv_core.sv
// Iterative multiply/divide datapath.
// Works on operand magnitudes in a 2*W accumulator: shift-add for multiply,
// restoring subtract-shift for divide, one step per i_step. Results are
// presented for the state *after* the current step so the controller can
// capture them at the edge that performs the final step.
//   i_load        : capture operands/op class (magnitudes and result signs)
//   i_step        : perform one iteration
//   i_is_div      : load-time op class (1 = divide)
//   i_signed      : load-time signedness
//   i_a / i_b     : rs / rt operands
//   o_res_hi/lo   : sign-corrected result as of the end of this step
module exe_muldiv_core
  import exe_muldiv_pkg::*;
#(
  parameter int unsigned W = MULDIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_step,
  input  logic         i_is_div,
  input  logic         i_signed,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_res_hi,
  output logic [W-1:0] o_res_lo
);

  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_opnd;   // multiplicand (mul) or divisor (div) magnitude
  logic           r_is_div;
  logic           r_neg_q;  // negate product / quotient
  logic           r_neg_r;  // negate remainder
  logic           r_divz;

  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic [W:0]     w_sum;
  logic [W:0]     w_rem;
  logic [W:0]     w_diff;
  logic [2*W-1:0] w_acc_nxt;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rmd;

  assign w_a_mag = (i_signed && i_a[W-1]) ? (~i_a + 1'b1) : i_a;
  assign w_b_mag = (i_signed && i_b[W-1]) ? (~i_b + 1'b1) : i_b;

  // Multiply: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift right (carry goes into the top).
  assign w_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_opnd};
  // Divide: shift left one bit and try subtracting the divisor; the partial
  // remainder can briefly need W+1 bits before the subtract.
  assign w_rem  = r_acc[2*W-1:W-1];
  assign w_diff = w_rem - {1'b0, r_opnd};

  always_comb begin
    w_acc_nxt = r_acc;
    if (r_is_div) begin
      if (!w_diff[W]) w_acc_nxt = {w_diff[W-1:0], r_acc[W-2:0], 1'b1};
      else            w_acc_nxt = {w_rem[W-1:0], r_acc[W-2:0], 1'b0};
    end else begin
      if (r_acc[0]) w_acc_nxt = {w_sum, r_acc[W-1:1]};
      else          w_acc_nxt = {1'b0, r_acc[2*W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_divz   <= 1'b0;
    end else if (i_load) begin
      r_acc    <= {{W{1'b0}}, (i_is_div ? w_a_mag : w_b_mag)};
      r_opnd   <= i_is_div ? w_b_mag : w_a_mag;
      r_is_div <= i_is_div;
      r_neg_q  <= i_signed && (i_a[W-1] ^ i_b[W-1]);
      r_neg_r  <= i_signed && i_a[W-1];
      r_divz   <= (i_b == '0);
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
    end
  end

  // Sign fix-up. With a zero divisor the remainder naturally ends as |rs|,
  // so re-applying rs's sign returns rs itself; the quotient is forced.
  assign w_prod = r_neg_q ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
  assign w_quo  = r_divz ? {W{1'b1}}
                         : (r_neg_q ? (~w_acc_nxt[W-1:0] + 1'b1) : w_acc_nxt[W-1:0]);
  assign w_rmd  = r_neg_r ? (~w_acc_nxt[2*W-1:W] + 1'b1) : w_acc_nxt[2*W-1:W];

  assign o_res_hi = r_is_div ? w_rmd : w_prod[2*W-1:W];
  assign o_res_lo = r_is_div ? w_quo : w_prod[W-1:0];

endmodule

// File: rtl/exe_muldiv.sv
// EXE-stage multiply/divide unit: FSM, iteration counter, HI/LO and stall.
//   clk, rst (async, active-high)
//   i_start, i_op, i_rs_data, i_rt_data : EXE instruction from ID/EX
//   i_flush     : squash the in-flight operation
//   o_stall_req : combinational pipeline hold
//   o_busy      : FSM not idle
//   o_done      : one-cycle pulse after HI/LO written by mul/div
//   o_hi, o_lo  : architectural HI/LO
module exe_muldiv
  import exe_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_data,
  input  logic [WIDTH-1:0] i_rt_data,
  input  logic             i_flush,
  output logic             o_stall_req,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_load = (r_state == ST_IDLE) && i_start && !i_flush && is_muldiv(i_op);
  assign w_step = (r_state == ST_CALC) && !i_flush;

  exe_muldiv_core #(
    .W (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (is_div_op(i_op)),
    .i_signed (is_signed_op(i_op)),
    .i_a      (i_rs_data),
    .i_b      (i_rt_data),
    .o_res_hi (w_res_hi),
    .o_res_lo (w_res_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state <= ST_CALC;
            r_cnt   <= CW'(WIDTH - 1);
          end else if (i_start && !i_flush && (i_op == OP_MTHI)) begin
            r_hi <= i_rs_data;
          end else if (i_start && !i_flush && (i_op == OP_MTLO)) begin
            r_lo <= i_rs_data;
          end
        end
        ST_CALC: begin
          if (i_flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            // Final step happens at this edge; core output already reflects it.
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_stall_req = w_load || w_step;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = r_done;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;

endmodule

// File: tb/tb_exe_muldiv.sv
module tb_exe_muldiv;
  import exe_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_rs_data;
  logic [31:0] i_rt_data;
  logic        i_flush;
  logic        o_stall_req;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int n_checks = 0;
  int n_errors = 0;

  exe_muldiv #(
    .WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_rs_data   (i_rs_data),
    .i_rt_data   (i_rt_data),
    .i_flush     (i_flush),
    .o_stall_req (o_stall_req),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_hi        (o_hi),
    .o_lo        (o_lo)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the architectural definition, returns {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic [31:0]        q;
    logic [31:0]        r;
    if (op == OP_MULT) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return sp;
    end
    if (op == OP_MULTU) begin
      up = {32'd0, a} * {32'd0, b};
      return up;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == OP_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  // Issue one op at the current (post-negedge) point, run to the done pulse.
  // Returns cycle index of done (-1 on timeout) and number of stall cycles.
  task automatic exec_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int done_cyc, output int stall_cyc);
    i_start = 1'b1; i_op = op; i_rs_data = a; i_rt_data = b;
    #1;
    stall_cyc = o_stall_req ? 1 : 0;
    done_cyc  = -1;
    @(negedge clk);
    i_start = 1'b0; i_op = OP_NONE;
    #1;
    for (int c = 1; c <= 60; c++) begin
      if (o_stall_req === 1'b1) stall_cyc++;
      if (o_done === 1'b1) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_op = OP_NONE; i_rs_data = '0; i_rt_data = '0; i_flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({o_hi, o_lo, o_busy, o_done, o_stall_req} !== 67'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got hi=%h lo=%h busy=%b done=%b stall=%b, want all 0",
               o_hi, o_lo, o_busy, o_done, o_stall_req);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release_idle: busy=%b want 0", o_busy);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [7];
    logic [31:0] as  [7];
    logic [31:0] bs  [7];
    logic [31:0] ehi [7];
    logic [31:0] elo [7];
    int d, s;
    ops[0] = OP_MULT;  as[0] = 32'hFFFF_FFFE; bs[0] = 32'd3;
    ehi[0] = 32'hFFFF_FFFF; elo[0] = 32'hFFFF_FFFA;
    ops[1] = OP_MULTU; as[1] = 32'hFFFF_FFFF; bs[1] = 32'hFFFF_FFFF;
    ehi[1] = 32'hFFFF_FFFE; elo[1] = 32'h0000_0001;
    ops[2] = OP_DIV;   as[2] = 32'hFFFF_FFF9; bs[2] = 32'd2;
    ehi[2] = 32'hFFFF_FFFF; elo[2] = 32'hFFFF_FFFD;
    ops[3] = OP_DIVU;  as[3] = 32'd100; bs[3] = 32'd7;
    ehi[3] = 32'd2; elo[3] = 32'd14;
    ops[4] = OP_DIVU;  as[4] = 32'h1234; bs[4] = 32'd0;
    ehi[4] = 32'h1234; elo[4] = 32'hFFFF_FFFF;
    ops[5] = OP_DIV;   as[5] = 32'h8000_0000; bs[5] = 32'hFFFF_FFFF;
    ehi[5] = 32'd0; elo[5] = 32'h8000_0000;
    ops[6] = OP_DIV;   as[6] = 32'hFFFF_FF00; bs[6] = 32'd0;
    ehi[6] = 32'hFFFF_FF00; elo[6] = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) begin
      exec_op(ops[i], as[i], bs[i], d, s);
      n_checks++;
      if (d !== 33 || s !== 33) begin
        n_errors++;
        $display("FAIL directed_timing[%0d]: done_cycle=%0d stall_cycles=%0d, want 33/33",
                 i, d, s);
      end
      n_checks++;
      if (o_hi !== ehi[i] || o_lo !== elo[i]) begin
        n_errors++;
        $display("FAIL directed_result[%0d]: hi=%h lo=%h, want hi=%h lo=%h",
                 i, o_hi, o_lo, ehi[i], elo[i]);
      end
      @(negedge clk); #1;
      n_checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
        n_errors++;
        $display("FAIL directed_idle[%0d]: busy=%b done=%b, want 0/0", i, o_busy, o_done);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    int d, s;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (i % 6 == 5) a = 32'h8000_0000;
      exp = ref_model(op, a, b);
      exec_op(op, a, b, d, s);
      n_checks++;
      if (d !== 33 || {o_hi, o_lo} !== exp) begin
        n_errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: done=%0d hi=%h lo=%h, want 33 hi=%h lo=%h",
                 i, op, a, b, d, o_hi, o_lo, exp[63:32], exp[31:0]);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_mthi_mtlo_flush();
    int seen_done;
    i_start = 1'b1; i_op = OP_MTHI; i_rs_data = 32'hA5A5_A5A5;
    #1;
    n_checks++;
    if (o_stall_req !== 1'b0) begin
      n_errors++;
      $display("FAIL mthi_stall: stall=%b want 0", o_stall_req);
    end
    @(negedge clk);
    i_op = OP_MTLO; i_rs_data = 32'h5A5A_5A5A;
    #1;
    n_checks++;
    if (o_hi !== 32'hA5A5_A5A5 || o_stall_req !== 1'b0 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mthi_write: hi=%h stall=%b busy=%b, want A5A5A5A5/0/0",
               o_hi, o_stall_req, o_busy);
    end
    @(negedge clk);
    i_op = OP_DIV; i_rs_data = 32'd1000; i_rt_data = 32'd3;
    #1;
    n_checks++;
    if (o_lo !== 32'h5A5A_5A5A || o_hi !== 32'hA5A5_A5A5 || o_stall_req !== 1'b1) begin
      n_errors++;
      $display("FAIL mtlo_write: hi=%h lo=%h stall=%b, want A5A5A5A5/5A5A5A5A/1",
               o_hi, o_lo, o_stall_req);
    end
    @(negedge clk);
    i_start = 1'b0; i_op = OP_NONE;
    repeat (9) @(negedge clk);
    // now in cycle 10 of the divide
    i_flush = 1'b1;
    #1;
    n_checks++;
    if (o_busy !== 1'b1 || o_stall_req !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_cycle: busy=%b stall=%b, want 1/0", o_busy, o_stall_req);
    end
    @(negedge clk);
    i_flush = 1'b0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_hi !== 32'hA5A5_A5A5 || o_lo !== 32'h5A5A_5A5A) begin
      n_errors++;
      $display("FAIL flush_idle: busy=%b hi=%h lo=%h, want 0/A5A5A5A5/5A5A5A5A",
               o_busy, o_hi, o_lo);
    end
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_done !== 1'b0 || o_busy !== 1'b0) seen_done++;
      @(negedge clk); #1;
    end
    n_checks++;
    if (seen_done != 0 || o_lo !== 32'h5A5A_5A5A) begin
      n_errors++;
      $display("FAIL flush_no_done: active cycles=%0d lo=%h, want 0/5A5A5A5A", seen_done, o_lo);
    end
  endtask

  task automatic test_ignored();
    logic [2:0] ops [3];
    logic       fl  [3];
    ops[0] = OP_NONE; fl[0] = 1'b0;
    ops[1] = 3'd7;    fl[1] = 1'b0;
    ops[2] = OP_DIV;  fl[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_start = 1'b1; i_op = ops[i]; i_flush = fl[i];
      i_rs_data = 32'hDEAD_BEEF; i_rt_data = 32'd5;
      #1;
      n_checks++;
      if (o_stall_req !== 1'b0) begin
        n_errors++;
        $display("FAIL ignored_stall[%0d]: stall=%b want 0", i, o_stall_req);
      end
      @(negedge clk);
      i_start = 1'b0; i_flush = 1'b0; i_op = OP_NONE;
      #1;
      n_checks++;
      if (o_busy !== 1'b0 || o_hi !== 32'hA5A5_A5A5 || o_lo !== 32'h5A5A_5A5A) begin
        n_errors++;
        $display("FAIL ignored_state[%0d]: busy=%b hi=%h lo=%h, want 0/A5A5A5A5/5A5A5A5A",
                 i, o_busy, o_hi, o_lo);
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    int d, s;
    i_start = 1'b1; i_op = OP_MULT; i_rs_data = 32'h1234_5678; i_rt_data = 32'h9ABC_DEF0;
    @(negedge clk);
    i_start = 1'b0; i_op = OP_NONE;
    repeat (14) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({o_hi, o_lo, o_busy, o_done, o_stall_req} !== 67'd0) begin
      n_errors++;
      $display("FAIL reset_mid_calc: hi=%h lo=%h busy=%b done=%b stall=%b, want all 0",
               o_hi, o_lo, o_busy, o_done, o_stall_req);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    exec_op(OP_MULTU, 32'd6, 32'd7, d, s);
    n_checks++;
    if (d !== 33 || o_hi !== 32'd0 || o_lo !== 32'd42) begin
      n_errors++;
      $display("FAIL reset_then_multu: done=%0d hi=%h lo=%h, want 33 hi=0 lo=2a", d, o_hi, o_lo);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int d, s;
    exec_op(OP_DIVU, 32'd100, 32'd7, d, s);
    n_checks++;
    if (d !== 33 || o_hi !== 32'd2 || o_lo !== 32'd14) begin
      n_errors++;
      $display("FAIL b2b_first: done=%0d hi=%h lo=%h, want 33 hi=2 lo=e", d, o_hi, o_lo);
    end
    // Present the next op while still in DONE: it must not be taken there.
    i_start = 1'b1; i_op = OP_MULTU; i_rs_data = 32'd5; i_rt_data = 32'd9;
    #1;
    n_checks++;
    if (o_stall_req !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_done_stall: stall=%b want 0", o_stall_req);
    end
    @(negedge clk); #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_stall_req !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_issue: busy=%b stall=%b, want 0/1", o_busy, o_stall_req);
    end
    exec_op(OP_MULTU, 32'd5, 32'd9, d, s);
    n_checks++;
    if (d !== 33 || s !== 33 || o_hi !== 32'd0 || o_lo !== 32'd45) begin
      n_errors++;
      $display("FAIL b2b_second: done=%0d stall=%0d hi=%h lo=%h, want 33/33 hi=0 lo=2d",
               d, s, o_hi, o_lo);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mthi_mtlo_flush();
    test_ignored();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
